// File: rtl/dbus_wait_slave.sv
// DBus scratchpad responder: word-organised RAM that answers every access after a
// fixed number of nak (wait) cycles, with per-byte write enables.
module dbus_wait_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int WAIT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  dm,
  output logic [31:0] dout,
  output logic        nak
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
      $error("dbus_wait_slave: WAIT must be in 1..15");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             din_q;
  logic                    we_q;
  logic [3:0]              dm_q;
  logic [31:0]             dout_q;

  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx_in;
  logic                    wr_en;
  logic                    unused_addr_bits;

  assign idx_in           = addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Completion is the BUSY cycle with the counter exhausted and the master still asking.
  assign nak   = stb && ((state_q == IDLE) || (cnt_q != 4'd0));
  assign wr_en = (state_q == BUSY) && stb && (cnt_q == 4'd0) && we_q;
  assign dout  = dout_q;

  // NOTE: every register below is written with <= so all of them sample the
  // pre-edge values together; = here would let later lines see updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      din_q   <= 32'h0;
      we_q    <= 1'b0;
      dm_q    <= 4'h0;
      dout_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stb) begin
            idx_q   <= idx_in;
            din_q   <= din;
            we_q    <= we;
            dm_q    <= dm;
            cnt_q   <= 4'(WAIT - 1);
            dout_q  <= mem[idx_in];
            state_q <= BUSY;
          end
        end
        BUSY: begin
          dout_q <= mem[idx_q];
          if (!stb) begin
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM array deliberately has no reset; contents survive rst and the
  // array can map onto block RAM. A reset-time write is dropped because state_q
  // leaves BUSY asynchronously, which clears wr_en.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_q[b]) mem[idx_q][8*b +: 8] <= din_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_wait_slave.sv
// Bench for dbus_wait_slave: three builds (WAIT 2, 1, 15) driven by directed and
// random accesses, checked against a word-array memory model and a latency rule.
module tb_dbus_wait_slave;

  logic        clk;
  logic        rst_n;
  logic        stb_s  [3];
  logic        we_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] din_s  [3];
  logic [3:0]  dm_s   [3];
  logic [31:0] dout_s [3];
  logic        nak_s  [3];

  int          waits [3] = '{2, 1, 15};
  logic [31:0] mdl   [3][1024];
  bit          known [3][1024];
  int          total = 0;
  int          bad   = 0;

  dbus_wait_slave #(.ADDR_WIDTH(10), .WAIT(2)) dut0 (
    .clk(clk), .rst(rst_n), .addr(addr_s[0]), .din(din_s[0]), .stb(stb_s[0]),
    .we(we_s[0]), .dm(dm_s[0]), .dout(dout_s[0]), .nak(nak_s[0]));
  dbus_wait_slave #(.ADDR_WIDTH(10), .WAIT(1)) dut1 (
    .clk(clk), .rst(rst_n), .addr(addr_s[1]), .din(din_s[1]), .stb(stb_s[1]),
    .we(we_s[1]), .dm(dm_s[1]), .dout(dout_s[1]), .nak(nak_s[1]));
  dbus_wait_slave #(.ADDR_WIDTH(10), .WAIT(15)) dut2 (
    .clk(clk), .rst(rst_n), .addr(addr_s[2]), .din(din_s[2]), .stb(stb_s[2]),
    .we(we_s[2]), .dm(dm_s[2]), .dout(dout_s[2]), .nak(nak_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  // Called #1 after a posedge; returns #1 after the posedge that ends the access
  // (plus one idle cycle when stb is released).
  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit hold,
                        input string tag);
    int          n;
    int          idx;
    logic [31:0] exp;
    bit          kn;
    idx = word_of(a);
    exp = mdl[k][idx];
    kn  = known[k][idx];
    stb_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; din_s[k] = d; dm_s[k] = m;
    n = 0;
    forever begin
      @(negedge clk);
      if (!nak_s[k]) break;
      n++;
      if (n > 40) break;
      @(posedge clk); #1;
      // The responder must work from the captured request, so scramble the bus.
      we_s[k] = 1'($urandom); addr_s[k] = $urandom; din_s[k] = $urandom; dm_s[k] = 4'($urandom);
    end
    check({tag, "_nak_cycles"}, 32'(n), 32'(waits[k]));
    if (!w && kn) check({tag, "_dout"}, dout_s[k], exp);
    if (w && n <= 40) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
      if (m == 4'hF) known[k][idx] = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin
      stb_s[k] = 1'b0;
      @(negedge clk);
      check({tag, "_nak_idle"}, 32'(nak_s[k]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    logic [31:0] alist [8];
    logic [31:0] v;
    alist = '{32'h0, 32'h4, 32'h8, 32'h1000, 32'hFFC, 32'h2004, 32'h50, 32'h54};
    for (int k = 0; k < 3; k++) begin
      stb_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'h0; din_s[k] = 32'h0; dm_s[k] = 4'h0;
    end
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_dout%0d", k), dout_s[k], 32'h0);
      check($sformatf("reset_nak%0d", k), 32'(nak_s[k]), 32'd0);
    end
    stb_s[0] = 1'b1;
    #1 check("reset_nak_follows_stb", 32'(nak_s[0]), 32'd1);
    stb_s[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10");
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd10");
    check("rd10_value", mdl[0][4], 32'hDEADBEEF);

    // Byte mask, then an all-disabled write
    access(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 1'b0, "pre14");
    access(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, "mask14");
    access(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "rd14");
    check("mask_model", mdl[0][5], 32'h11BB33DD);
    access(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b0, "dm0_14");
    access(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, "rd14_after_dm0");

    // Back-to-back with stb held across completion
    access(0, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 1'b1, "b2b_wr20");
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "b2b_rd20");

    // Abort after one cycle
    access(0, 1'b1, 32'h30, 32'h00000000, 4'hF, 1'b0, "pre30");
    stb_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h30; din_s[0] = 32'hFFFFFFFF; dm_s[0] = 4'hF;
    @(negedge clk);
    check("abort_nak_first", 32'(nak_s[0]), 32'd1);
    @(posedge clk); #1;
    stb_s[0] = 1'b0;
    @(negedge clk);
    check("abort_nak_dropped", 32'(nak_s[0]), 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, "abort_rd30");

    // Reset in the middle of a write; stb stays up and turns into a read
    access(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, "pre40");
    stb_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; din_s[0] = 32'hCAFEF00D; dm_s[0] = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    we_s[0] = 1'b0;
    #1;
    check("midrst_dout", dout_s[0], 32'h0);
    check("midrst_nak", 32'(nak_s[0]), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    access(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, "midrst_rd40");

    // Aliasing on the WAIT=1 and WAIT=15 builds
    for (int k = 1; k < 3; k++) begin
      v = $urandom;
      access(k, 1'b1, 32'h0, v, 4'hF, 1'b0, $sformatf("alias%0d_wr0", k));
      access(k, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, $sformatf("alias%0d_rd1000", k));
      v = $urandom;
      access(k, 1'b1, 32'h1000, v, 4'hF, 1'b0, $sformatf("alias%0d_wr1000", k));
      access(k, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, $sformatf("alias%0d_rd0", k));
    end

    // Random traffic over a small aliasing address set
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++)
        access(k, 1'b1, alist[i], $urandom, 4'hF, 1'b0, $sformatf("rpre%0d_%0d", k, i));
      for (int i = 0; i < 25; i++)
        access(k, 1'($urandom), alist[$urandom_range(7, 0)], $urandom, 4'($urandom),
               1'($urandom), $sformatf("rnd%0d_%0d", k, i));
      stb_s[k] = 1'b0;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
